// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: load/store ops, FSM states, owner.
package mem_arbiter_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned OP_W   = 3;

   localparam logic [OP_W-1:0] LS_LW  = 3'b000;
   localparam logic [OP_W-1:0] LS_SB  = 3'b001;
   localparam logic [OP_W-1:0] LS_SH  = 3'b010;
   localparam logic [OP_W-1:0] LS_SW  = 3'b011;
   localparam logic [OP_W-1:0] LS_LB  = 3'b100;
   localparam logic [OP_W-1:0] LS_LH  = 3'b101;
   localparam logic [OP_W-1:0] LS_LBU = 3'b110;
   localparam logic [OP_W-1:0] LS_LHU = 3'b111;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_REQ  = 4'b0010,
      ST_RESP = 4'b0100,
      ST_ERR  = 4'b1000
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arbiter_ls_align.sv
// Load/store lane logic: misalignment check, byte enables, store replication,
// and load extraction with sign/zero extension.
module ls_align
   import mem_arbiter_pkg::*;
(
   input  logic [OP_W-1:0]   op,
   input  logic [1:0]        offset,
   input  logic [WORD_W-1:0] wdata,
   input  logic [WORD_W-1:0] rdata,
   output logic              misaligned_c,
   output logic              we_c,
   output logic [BE_W-1:0]   be_c,
   output logic [WORD_W-1:0] wdata_c,
   output logic [WORD_W-1:0] rdata_c
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte      = 8'(rdata >> {offset, 3'b000});
      ld_half      = 16'(rdata >> {offset[1], 4'b0000});
      misaligned_c = 1'b0;
      we_c         = 1'b0;
      be_c         = 4'b1111;
      wdata_c      = '0;
      rdata_c      = '0;
      case (op)
         LS_LW: begin
            misaligned_c = (offset != 2'b00);
            rdata_c      = rdata;
         end
         LS_SB: begin
            we_c    = 1'b1;
            be_c    = 4'b0001 << offset;
            wdata_c = {4{wdata[7:0]}};
         end
         LS_SH: begin
            misaligned_c = offset[0];
            we_c         = 1'b1;
            be_c         = 4'b0011 << {offset[1], 1'b0};
            wdata_c      = {2{wdata[15:0]}};
         end
         LS_SW: begin
            misaligned_c = (offset != 2'b00);
            we_c         = 1'b1;
            wdata_c      = wdata;
         end
         LS_LB:  rdata_c = {{24{ld_byte[7]}}, ld_byte};
         LS_LH: begin
            misaligned_c = offset[0];
            rdata_c      = {{16{ld_half[15]}}, ld_half};
         end
         LS_LBU: rdata_c = {24'h000000, ld_byte};
         LS_LHU: begin
            misaligned_c = offset[0];
            rdata_c      = {16'h0000, ld_half};
         end
         default: rdata_c = '0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// outstanding transaction at a time, with bounded starvation of fetch.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [XLEN-1:0] if_rdata,
   input  logic            ls_req,
   input  logic [2:0]      ls_op,
   input  logic [XLEN-1:0] ls_addr,
   input  logic [XLEN-1:0] ls_wdata,
   output logic            ls_gnt,
   output logic            ls_rvalid,
   output logic [XLEN-1:0] ls_rdata,
   output logic            ls_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ready,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int unsigned CNT_W   = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

   state_t           state;
   owner_t           owner;
   logic [OP_W-1:0]  lat_op;
   logic [1:0]       lat_off;
   logic [CNT_W-1:0] starve_cnt;

   logic             ls_win_c;
   logic [XLEN-1:0]  sel_addr_c;
   logic [OP_W-1:0]  al_op_c;
   logic [1:0]       al_off_c;
   logic             al_mis_c;
   logic             al_we_c;
   logic [BE_W-1:0]  al_be_c;
   logic [XLEN-1:0]  al_wdata_c;
   logic [XLEN-1:0]  al_rdata_c;

   // Lane logic sees the live LS request while arbitrating, the latched one otherwise
   always_comb begin
      ls_win_c   = ls_req && (!if_req || (starve_cnt < CNT_W'(STARVE_LIMIT)));
      sel_addr_c = ls_win_c ? ls_addr : if_addr;
      al_op_c    = (state == ST_IDLE) ? ls_op : lat_op;
      al_off_c   = (state == ST_IDLE) ? sel_addr_c[1:0] : lat_off;
   end

   ls_align u_ls_align (
      .op           (al_op_c),
      .offset       (al_off_c),
      .wdata        (ls_wdata),
      .rdata        (mem_rdata),
      .misaligned_c (al_mis_c),
      .we_c         (al_we_c),
      .be_c         (al_be_c),
      .wdata_c      (al_wdata_c),
      .rdata_c      (al_rdata_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         owner      <= OWN_IF;
         lat_op     <= LS_LW;
         lat_off    <= 2'b00;
         starve_cnt <= '0;
         if_gnt     <= 1'b0;
         if_rvalid  <= 1'b0;
         if_rdata   <= '0;
         ls_gnt     <= 1'b0;
         ls_rvalid  <= 1'b0;
         ls_rdata   <= '0;
         ls_err     <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         if_gnt    <= 1'b0;
         ls_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         ls_rvalid <= 1'b0;
         ls_err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!if_req) starve_cnt <= '0;
               lat_off <= sel_addr_c[1:0];
               if (ls_win_c) begin
                  owner  <= OWN_LS;
                  lat_op <= ls_op;
                  ls_gnt <= 1'b1;
                  if (if_req && (starve_cnt != CNT_MAX)) starve_cnt <= starve_cnt + 1'b1;
                  if (al_mis_c) begin
                     state <= ST_ERR;
                  end else begin
                     state     <= ST_REQ;
                     mem_req   <= 1'b1;
                     mem_we    <= al_we_c;
                     mem_be    <= al_be_c;
                     mem_addr  <= {sel_addr_c[XLEN-1:2], 2'b00};
                     mem_wdata <= al_wdata_c;
                  end
               end else if (if_req) begin
                  owner      <= OWN_IF;
                  starve_cnt <= '0;
                  if_gnt     <= 1'b1;
                  state      <= ST_REQ;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_be     <= 4'b1111;
                  mem_addr   <= {sel_addr_c[XLEN-1:2], 2'b00};
                  mem_wdata  <= '0;
               end
            end
            ST_REQ: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (mem_rvalid) begin
                  state <= ST_IDLE;
                  if (owner == OWN_IF) begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= mem_rdata;
                  end else begin
                     ls_rvalid <= 1'b1;
                     ls_rdata  <= al_rdata_c;
                  end
               end
            end
            ST_ERR: begin
               state     <= ST_IDLE;
               ls_rvalid <= 1'b1;
               ls_err    <= 1'b1;
               ls_rdata  <= '0;
            end
            default: begin
               state   <= ST_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (IF) and the load/store requester (LS) of the multi-cycle RV32I core.
- Arbitrates between them, sequences one outstanding memory transaction at a time, and generates byte enables and store-data lane replication.
- Extracts and extends load data, and flags misaligned LS accesses without touching memory.
- Sits between the control unit's fetch/MEM states and the memory.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- STARVE_LIMIT, 4, maximum consecutive LS grants while if_req is pending before IF is forced; range 1-15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  XLEN  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  XLEN  fetched word
- ls_req  in  1  load/store request; held with ls_op/ls_addr/ls_wdata until ls_gnt
- ls_op  in  3  000 lw, 001 sb, 010 sh, 011 sw, 100 lb, 101 lh, 110 lbu, 111 lhu
- ls_addr  in  XLEN  byte address
- ls_wdata  in  XLEN  store data, right-aligned
- ls_gnt  out  1  one-cycle pulse: LS request accepted
- ls_rvalid  out  1  one-cycle pulse: LS completed (load data or store ack)
- ls_rdata  out  XLEN  extended load data; 0 for stores and errors
- ls_err  out  1  valid with ls_rvalid: misaligned access
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables
- mem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  XLEN  lane-replicated store data
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data or write ack; at least 1 cycle after acceptance
- mem_rdata  in  XLEN  read word

Behaviour:
- All outputs are registered. On reset, the FSM goes to IDLE and every output is 0. starve_cnt is cleared.
- States: IDLE, REQ, RESP, ERR.
- IDLE, request sampled at a clock edge:
  - LS wins if ls_req and (!if_req or starve_cnt < STARVE_LIMIT); otherwise IF wins if if_req.
  - The winner's op, address and data are latched.
  - Aligned request: go to REQ. Misaligned LS request: go to ERR.
- starve_cnt:
  - increments (saturating) on each LS grant while if_req=1;
  - clears on an IF grant, or whenever if_req=0 in IDLE.
- Misalignment rules: lw/sw need addr[1:0]=0; lh/lhu/sh need addr[0]=0; byte ops are never misaligned.
- REQ:
  - mem_req=1 with latched we/be/addr/wdata.
  - The winner's gnt pulses in the first REQ cycle only.
  - On mem_ready=1, go to RESP with mem_req=0 next cycle.
  - mem_rvalid is ignored in REQ.
- RESP: on mem_rvalid=1, go to IDLE. Next cycle the owner's rvalid=1 with data (if_rdata=mem_rdata; ls_rdata extended). Arbitration of new requests resumes in that same cycle.
- ERR (one cycle): ls_gnt=1; then IDLE with ls_rvalid=1, ls_err=1, ls_rdata=0. No mem_req is issued. The access counts as an LS grant for starve_cnt.
- Byte enables and store data:
  - sb: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - sh: be=0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - sw: be=1111.
  - Loads: we=0, be=1111.
- Load extraction: byte = mem_rdata>>(8*addr[1:0]); half = mem_rdata>>(16*addr[1]). lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- Minimum latency with ready=1 and rvalid one cycle later: sample edge T0, gnt at T1, mem accepted at T1, rvalid at T2, requester rvalid at T3.
- Requesters drop req after seeing gnt; a req still high in IDLE is treated as a new request.
- Reset mid-transaction: mem_req drops immediately (async). A later stray mem_rvalid in IDLE is ignored.

Decomposition:
- Shared package holds:
  - LS op encodings: LS_LW, LS_SB, LS_SH, LS_SW, LS_LB, LS_LH, LS_LBU, LS_LHU;
  - FSM state encodings (one-hot, 4 bits);
  - owner encoding OWN_IF/OWN_LS.
- One combinational sub-module, ls_align: misalignment check, be/wdata generation, load extract/extend.

Test Plan:
- IF only, if_addr=0x100, mem_ready=1, mem_rdata=0xDEADBEEF one cycle later -> if_gnt at T1, mem_addr=0x100/be=1111/we=0, if_rvalid at T3 with 0xDEADBEEF.
- Simultaneous if_req and ls_req (lw 0x200), STARVE_LIMIT=4, LS re-requests continuously -> 4 LS grants, then the IF grant; starve_cnt clears.
- sb addr=0x203 wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200, we=1; ls_rvalid on ack with ls_rdata=0.
- lb/lbu addr=0x102, mem_rdata=0x12F03456 -> lb gives 0xFFFFFFF0, lbu gives 0x000000F0; lh addr=0x102 gives 0x000012F0.
- lw addr=0x101 -> no mem_req; ls_gnt pulse, then ls_rvalid=1, ls_err=1, ls_rdata=0.
- mem_ready held low 3 cycles, then rst=0 during REQ -> mem_req falls asynchronously, all outputs 0; a subsequent mem_rvalid produces no rvalid.
